aes_iter_ctrl: RTL and testbench

AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

---
 rtl/aes_iter_ctrl_pkg.sv | 117 +++++++++++
 rtl/aes_iter_ctrl_round.sv | 12 +
 rtl/aes_iter_ctrl.sv | 108 ++++++++++
 tb/tb_aes_iter_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_iter_ctrl_pkg.sv
// Shared constants, FSM encoding and AES-128 transform functions.
// The S-box is computed (GF(2^8) inverse + affine map) rather than tabulated.
package aes_iter_ctrl_pkg;

  localparam int NR     = 10;
  localparam int NK     = 4;
  localparam int BLK_W  = 128;
  localparam int EK_W   = BLK_W * (NR + 1);
  localparam int RIDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] add_round_key(input logic [BLK_W-1:0] s,
                                                     input logic [BLK_W-1:0] k);
    return s ^ k;
  endfunction

  // Word 0 of the schedule lands in the MSBs, so round key 0 is the top slice.
  function automatic logic [EK_W-1:0] key_expansion(input logic [32*NK-1:0] key);
    logic [31:0] w [0:4*(NR+1)-1];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [EK_W-1:0] ek;
    rc = 8'h01;
    ek = '0;
    for (int i = 0; i < 4*(NR+1); i++) begin
      if (i < NK) begin
        w[i] = key[32*NK-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
          rc = xtime(rc);
        end
        w[i] = w[i-NK] ^ t;
      end
      ek[EK_W-1-32*i -: 32] = w[i];
    end
    return ek;
  endfunction

  function automatic logic [BLK_W-1:0] round_key(input logic [EK_W-1:0] ek,
                                                 input logic [RIDX_W-1:0] r);
    return ek[EK_W-1-BLK_W*int'(r) -: BLK_W];
  endfunction

endpackage

// File: rtl/aes_iter_ctrl_round.sv
// One full AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module aes_iter_ctrl_round
  import aes_iter_ctrl_pkg::*;
(
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rk_i,
  output logic [BLK_W-1:0] state_o
);

  assign state_o = add_round_key(mix_columns(shift_rows(sub_bytes(state_i))), rk_i);

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, registered ciphertext with
// valid/ready handshake.
//   state   | meaning
//   IDLE    | waiting for a job, in_ready high
//   ROUND   | applying full rounds 1..Nr-1, one per cycle
//   FINAL   | last round (no MixColumns), loads out
//   DONE    | out_valid high, waiting for out_ready
module aes_iter_ctrl
  import aes_iter_ctrl_pkg::*;
#(
  parameter int Nr = NR,
  parameter int Nk = NK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in,
  input  logic [32*Nk-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out,
  output logic              busy,
  output logic [RIDX_W-1:0] round_idx
);

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    data_q, data_d;
  logic [32*Nk-1:0]    key_q, key_d;
  logic [BLK_W-1:0]    out_q, out_d;
  logic [RIDX_W-1:0]   round_idx_q, round_idx_d;
  logic [EK_W-1:0]     ek;
  logic [BLK_W-1:0]    rk_cur;
  logic [BLK_W-1:0]    rk_last;
  logic [BLK_W-1:0]    round_out;

  // Schedule is derived from the captured key only, so input changes mid-job are inert.
  assign ek      = key_expansion(key_q);
  assign rk_cur  = round_key(ek, round_idx_q);
  assign rk_last = round_key(ek, RIDX_W'(Nr));

  aes_iter_ctrl_round u_round (
    .state_i (data_q),
    .rk_i    (rk_cur),
    .state_o (round_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      key_q       <= '0;
      out_q       <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      key_q       <= key_d;
      out_q       <= out_d;
      round_idx_q <= round_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    key_d       = key_q;
    out_d       = out_q;
    round_idx_d = round_idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Round key 0 is the cipher key itself, so use the port directly.
          key_d       = key;
          data_d      = add_round_key(in, key);
          round_idx_d = RIDX_W'(1);
          state_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        data_d      = round_out;
        round_idx_d = round_idx_q + RIDX_W'(1);
        if (round_idx_q == RIDX_W'(Nr - 1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        out_d   = add_round_key(shift_rows(sub_bytes(data_q)), rk_last);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          round_idx_d = '0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        round_idx_d = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign round_idx = round_idx_q;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed scoreboard bench for aes_iter_ctrl using FIPS-197 known-answer vectors.
module tb_aes_iter_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_IN   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_OUT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_d;
  logic [127:0] key_d;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;
  logic [3:0]   round_idx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [127:0] exp_q[$];

  aes_iter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_d),
    .key       (key_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [127:0] k, input logic [127:0] p);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 128'(in_ready), 128'(1));
    key_d    = k;
    in_d     = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", 128'(busy), 128'(1));
    check("round_idx_after_accept", 128'(round_idx), 128'(1));
  endtask

  // Accept edge ends cycle T; out_valid is first seen in cycle T+11, i.e. 10 edges later.
  task automatic wait_out(input string tag, input bit scramble);
    int lat;
    int exp_idx;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        key_d     = '1;
        in_d      = {$urandom, $urandom, $urandom, $urandom};
        in_valid  = (lat < 7);
        out_ready = 1'b1;
      end
      tick();
      lat++;
      if (!out_valid) begin
        exp_idx = (lat + 1 > 10) ? 10 : lat + 1;
        check("round_idx_seq", 128'(round_idx), 128'(exp_idx));
      end
    end
    in_valid = 1'b0;
    check("latency", 128'(lat), 128'(10));
    if (out_valid) begin
      check("round_idx_done", 128'(round_idx), 128'(10));
      if (exp_q.size() > 0) check(tag, out, exp_q.pop_front());
      else check("scoreboard_empty", 128'(exp_q.size()), 128'(1));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_release", 128'(out_valid), 128'(0));
    check("in_ready_after_release", 128'(in_ready), 128'(1));
    check("round_idx_idle", 128'(round_idx), 128'(0));
  endtask

  initial begin
    int seen;
    int acc;
    int outs;
    int n;
    int nr;
    int acc_cyc [2];
    logic [3:0] rec [10];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_d = '0; key_d = '0;
    tick();
    tick();
    check("rst_out", out, 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_round_idx", 128'(round_idx), 128'(0));
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", 128'(in_ready), 128'(1));

    exp_q.push_back(C1_OUT);
    start_job(C1_KEY, C1_IN);
    wait_out("c1_out", 1'b0);
    release_out();

    // Backpressure on the FIPS-197 appendix B vector.
    exp_q.push_back(B_OUT);
    start_job(B_KEY, B_IN);
    wait_out("b_out", 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_stable", out, B_OUT);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    release_out();

    exp_q.push_back(Z_OUT);
    start_job('0, '0);
    wait_out("zero_out", 1'b0);
    release_out();

    // Inputs scrambled and out_ready high while the job is in flight.
    exp_q.push_back(C1_OUT);
    start_job(C1_KEY, C1_IN);
    wait_out("keychg_out", 1'b1);
    release_out();

    // Reset at T+5 discards the job.
    start_job(C1_KEY, C1_IN);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_out", out, 128'(0));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_round_idx", 128'(round_idx), 128'(0));
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("midrst_no_out_valid", 128'(seen), 128'(0));
    exp_q.push_back(C1_OUT);
    start_job(C1_KEY, C1_IN);
    wait_out("post_rst_out", 1'b0);
    release_out();

    // Back-to-back: in_valid held, out_ready tied high.
    acc = 0; outs = 0; n = 0; nr = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    out_ready = 1'b1;
    key_d = C1_KEY; in_d = C1_IN; in_valid = 1'b1;
    while (outs < 2 && n < 60) begin
      if (in_ready && in_valid) begin
        acc_cyc[acc] = cyc;
        exp_q.push_back(acc == 0 ? C1_OUT : B_OUT);
        acc++;
      end
      tick();
      n++;
      if (acc == 1) begin
        key_d = B_KEY;
        in_d  = B_IN;
        if (nr < 10) begin
          rec[nr] = round_idx;
          nr++;
        end
      end
      if (acc == 2) in_valid = 1'b0;
      if (out_valid) begin
        if (exp_q.size() > 0) check("b2b_out", out, exp_q.pop_front());
        else check("b2b_scoreboard_empty", 128'(exp_q.size()), 128'(1));
        outs++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_outputs", 128'(outs), 128'(2));
    check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
    check("b2b_idx_samples", 128'(nr), 128'(10));
    for (int i = 0; i < 10; i++)
      check("b2b_round_idx", 128'(rec[i]), 128'((i < 9) ? i + 1 : 10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
